// File: rtl/ram_sdp_be_clr_if.sv
// Bus bundle for ram_sdp_be_clr: write port, read port, clear request and status.
// The master drives requests; the RAM (slave) returns busy, q and q_valid.
interface ram_sdp_be_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_MEMS   = 4
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] wraddress;
    logic [NUM_MEMS-1:0]   wren;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic                  rden;
    logic                  clear;
    logic                  busy;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;

    modport master (
        output data, wraddress, wren, rdaddress, rden, clear,
        input  busy, q, q_valid
    );

    modport slave (
        input  data, wraddress, wren, rdaddress, rden, clear,
        output busy, q, q_valid
    );
endinterface

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with per-lane byte enables, staged writes with read forwarding,
// optional output register and a hardware clear sweep that fills every word.
module ram_sdp_be_clr #(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    ADDR_WIDTH       = 8,
    parameter int                    ADDRESSABLE_SIZE = 8,
    parameter                        DATAFILE         = "",
    parameter bit                    DO_INIT          = 1'b1,
    parameter bit                    OUTPUT_REG       = 1'b0,
    parameter bit                    CLEAR_ON_RESET   = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE      = '0
) (
    input logic             clock,
    input logic             nReset,
    ram_sdp_be_clr_if.slave bus
);
    localparam int NUM_MEMS = DATA_WIDTH / ADDRESSABLE_SIZE;
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} stateType;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    stateType              state;
    logic [ADDR_WIDTH-1:0] sweepCount;
    logic [NUM_MEMS-1:0]   stageEn;
    logic [ADDR_WIDTH-1:0] stageAddr;
    logic [DATA_WIDTH-1:0] stageData;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic                  readValid;
    logic [DATA_WIDTH-1:0] readData;
    logic                  busyInt;

    assign busyInt  = (state == CLEAR);
    assign bus.busy = busyInt;

    // The clear sweep owns the write stage while busy, so user writes are simply not staged.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : IDLE;
            sweepCount <= '0;
            stageEn    <= '0;
            stageAddr  <= '0;
            stageData  <= '0;
        end else if (state == CLEAR) begin
            stageEn    <= '1;
            stageAddr  <= sweepCount;
            stageData  <= CLEAR_VALUE;
            sweepCount <= sweepCount + ADDR_WIDTH'(1);
            if (sweepCount == '1) begin
                state <= IDLE;
            end
        end else begin
            stageEn   <= bus.wren;
            stageAddr <= bus.wraddress;
            stageData <= bus.data;
            if (bus.clear) begin
                state <= CLEAR;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_MEMS; i++) begin
            if (stageEn[i]) begin
                mem[stageAddr][i*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE] <=
                    stageData[i*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE];
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            readAddr  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= bus.rden && !busyInt;
            if (bus.rden && !busyInt) begin
                readAddr <= bus.rdaddress;
            end
        end
    end

    // Lanes still sitting in the write stage override the array so reads never go stale.
    always_comb begin
        readData = mem[readAddr];
        for (int i = 0; i < NUM_MEMS; i++) begin
            if (stageEn[i] && (stageAddr == readAddr)) begin
                readData[i*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE] =
                    stageData[i*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE];
            end
        end
    end

    if (OUTPUT_REG) begin : gOutReg
        logic [DATA_WIDTH-1:0] qReg;
        logic                  qValidReg;

        always_ff @(posedge clock or negedge nReset) begin
            if (!nReset) begin
                qReg      <= '0;
                qValidReg <= 1'b0;
            end else begin
                qValidReg <= readValid;
                if (readValid) begin
                    qReg <= readData;
                end
            end
        end

        assign bus.q       = qReg;
        assign bus.q_valid = qValidReg && !busyInt;
    end else begin : gOutComb
        assign bus.q       = readData;
        assign bus.q_valid = readValid && !busyInt;
    end
endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Randomised and directed bench for ram_sdp_be_clr: two instances (latency 1 and 2,
// different clear patterns) share one stimulus stream and a word-level memory model.
module tb_ram_sdp_be_clr;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CLR0  = 32'h0000_0000;
    localparam logic [31:0] CLR1  = 32'hFFFF_FFFF;

    logic        clock     = 1'b0;
    logic        nReset    = 1'b1;
    logic [31:0] data      = '0;
    logic [3:0]  wraddress = '0;
    logic [3:0]  wren      = '0;
    logic [3:0]  rdaddress = '0;
    logic        rden      = 1'b0;
    logic        clear     = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];
    int          sweepLeft = 0;
    logic [3:0]  heldAddr  = '0;
    bit          accepted  = 1'b0;
    logic [31:0] q1Exp     = '0;
    bit          valid0Exp = 1'b0;
    bit          valid1Exp = 1'b0;

    ram_sdp_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_MEMS(4)) bus0 ();
    ram_sdp_be_clr_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_MEMS(4)) bus1 ();

    assign bus0.data = data;   assign bus0.wraddress = wraddress; assign bus0.wren  = wren;
    assign bus0.rdaddress = rdaddress; assign bus0.rden = rden;   assign bus0.clear = clear;
    assign bus1.data = data;   assign bus1.wraddress = wraddress; assign bus1.wren  = wren;
    assign bus1.rdaddress = rdaddress; assign bus1.rden = rden;   assign bus1.clear = clear;

    ram_sdp_be_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .ADDRESSABLE_SIZE(8), .DATAFILE(""), .DO_INIT(1'b1),
        .OUTPUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR0)
    ) dut0 (.clock(clock), .nReset(nReset), .bus(bus0.slave));

    ram_sdp_be_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .ADDRESSABLE_SIZE(8), .DATAFILE(""), .DO_INIT(1'b1),
        .OUTPUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR1)
    ) dut1 (.clock(clock), .nReset(nReset), .bus(bus1.slave));

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: drive at negedge, advance the model at the edge, compare at the next negedge.
    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] wa, input logic [3:0] we,
                                 input logic [3:0] ra, input logic rd, input logic clr);
        bit prevAccepted;
        data = d; wraddress = wa; wren = we; rdaddress = ra; rden = rd; clear = clr;
        @(posedge clock);
        prevAccepted = accepted;
        if (accepted) q1Exp = mem1[heldAddr];
        accepted = 1'b0;
        if (sweepLeft > 0) begin
            mem0[DEPTH - sweepLeft] = CLR0;
            mem1[DEPTH - sweepLeft] = CLR1;
            sweepLeft--;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (we[l]) begin
                    mem0[wa][l*8 +: 8] = d[l*8 +: 8];
                    mem1[wa][l*8 +: 8] = d[l*8 +: 8];
                end
            end
            if (rd) begin
                accepted = 1'b1;
                heldAddr = ra;
            end
            if (clr) sweepLeft = DEPTH;
        end
        valid0Exp = accepted && (sweepLeft == 0);
        valid1Exp = prevAccepted && (sweepLeft == 0);
        @(negedge clock);
        checkOutput("busy0", {31'b0, bus0.busy}, {31'b0, sweepLeft > 0});
        checkOutput("busy1", {31'b0, bus1.busy}, {31'b0, sweepLeft > 0});
        checkOutput("q0", bus0.q, mem0[heldAddr]);
        checkOutput("q_valid0", {31'b0, bus0.q_valid}, {31'b0, valid0Exp});
        checkOutput("q1", bus1.q, q1Exp);
        checkOutput("q_valid1", {31'b0, bus1.q_valid}, {31'b0, valid1Exp});
    endtask

    task automatic idle();
        applyStimulus(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic resetDut(input int cycles);
        data = '0; wraddress = '0; wren = '0; rdaddress = '0; rden = 1'b0; clear = 1'b0;
        nReset = 1'b0;
        sweepLeft = DEPTH; accepted = 1'b0; heldAddr = '0; q1Exp = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput("rst_busy0", {31'b0, bus0.busy}, 32'd1);
            checkOutput("rst_busy1", {31'b0, bus1.busy}, 32'd1);
            checkOutput("rst_q_valid0", {31'b0, bus0.q_valid}, 32'd0);
            checkOutput("rst_q_valid1", {31'b0, bus1.q_valid}, 32'd0);
        end
        nReset = 1'b1;
    endtask

    task automatic countSweep(input string tag);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (bus0.busy === 1'b1 && n < 40);
        checkOutput(tag, n, 32'd16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        @(negedge clock);
        resetDut(3);

        // Power-on sweep, then every word reads back as the clear pattern
        countSweep("t1_busy_cycles");
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(32'h0, 4'h0, 4'h0, 4'(a), 1'b1, 1'b0);
            checkOutput("t1_read_q0", bus0.q, CLR0);
        end
        idle();
        checkOutput("t1_last_q1", bus1.q, CLR1);

        // Partial lane merge
        applyStimulus(32'hAABB_CCDD, 4'd3, 4'b1111, 4'h0, 1'b0, 1'b0);
        applyStimulus(32'h1122_3344, 4'd3, 4'b0010, 4'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd3, 1'b1, 1'b0);
        checkOutput("t2_q0", bus0.q, 32'hAABB_33DD);
        idle();
        checkOutput("t2_q1", bus1.q, 32'hAABB_33DD);

        // Read right behind the write, and read/write of the same address on one edge
        applyStimulus(32'h1234_5678, 4'd5, 4'b1111, 4'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd5, 1'b1, 1'b0);
        checkOutput("t3_q0", bus0.q, 32'h1234_5678);
        checkOutput("t3_q_valid0", {31'b0, bus0.q_valid}, 32'd1);
        idle();
        checkOutput("t3_q1", bus1.q, 32'h1234_5678);
        checkOutput("t3_q_valid1", {31'b0, bus1.q_valid}, 32'd1);
        applyStimulus(32'h9ABC_DEF0, 4'd6, 4'b0101, 4'd6, 1'b1, 1'b0);
        checkOutput("t3_same_edge_q0", bus0.q, 32'h00BC_00F0);

        // Registered output holds while rden stays low
        applyStimulus(32'hCAFE_F00D, 4'd7, 4'b1111, 4'h0, 1'b0, 1'b0);
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd7, 1'b1, 1'b0);
        checkOutput("t4_q_valid1_early", {31'b0, bus1.q_valid}, 32'd0);
        idle();
        checkOutput("t4_q_valid1", {31'b0, bus1.q_valid}, 32'd1);
        checkOutput("t4_q1", bus1.q, 32'hCAFE_F00D);
        idle();
        checkOutput("t4_q_valid1_drop", {31'b0, bus1.q_valid}, 32'd0);
        applyStimulus(32'h0, 4'd7, 4'b1111, 4'h0, 1'b0, 1'b0);
        idle();
        idle();
        checkOutput("t4_q1_hold", bus1.q, 32'hCAFE_F00D);
        checkOutput("t4_q0_follow", bus0.q, 32'h0);

        // Clear pulse; writes and clears during the sweep are dropped
        applyStimulus(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        applyStimulus(32'h0, 4'd2, 4'b1111, 4'h0, 1'b0, 1'b1);
        for (int n = 0; n < 40 && bus0.busy === 1'b1; n++) idle();
        checkOutput("t5_busy_end", {31'b0, bus0.busy}, 32'd0);
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd2, 1'b1, 1'b0);
        checkOutput("t5_q0", bus0.q, CLR0);
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd15, 1'b1, 1'b0);
        checkOutput("t5_q1", bus1.q, CLR1);
        checkOutput("t5_q_valid1", {31'b0, bus1.q_valid}, 32'd1);
        idle();
        checkOutput("t5_last_word_q1", bus1.q, CLR1);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom, 4'($urandom_range(15)),
                          ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0,
                          4'($urandom_range(15)), 1'($urandom_range(1)),
                          ($urandom_range(63) == 0));
        end
        for (int n = 0; n < 40 && bus0.busy === 1'b1; n++) idle();

        // Reset in the middle of a sweep restarts it from address 0
        applyStimulus(32'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
        repeat (9) idle();
        resetDut(2);
        countSweep("t6_busy_cycles");
        applyStimulus(32'h0, 4'h0, 4'h0, 4'd8, 1'b1, 1'b0);
        checkOutput("t6_q0", bus0.q, CLR0);
        idle();
        checkOutput("t6_q1", bus1.q, CLR1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
